// File: rtl/akarin_pkg.sv
// akarin shared definitions
// arbiter state encoding and memory bus widths
package akarin_pkg;

  localparam int MEM_AW = 32;
  localparam int MEM_DW = 32;
  localparam int MEM_BW = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY_I,
    ST_BUSY_D,
    ST_RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory bus between ifetch and data ports
// one outstanding transaction, bounded data run, busy timeout
module mem_arbiter
  import akarin_pkg::*;
#(
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [MEM_AW-1:0] i_addr,
  output logic              i_ack,
  output logic [MEM_DW-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [MEM_AW-1:0] d_addr,
  input  logic [MEM_DW-1:0] d_wdata,
  input  logic [MEM_BW-1:0] d_be,
  output logic              d_ack,
  output logic [MEM_DW-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [MEM_DW-1:0] mem_wdata,
  output logic [MEM_BW-1:0] mem_be,
  input  logic              mem_ack,
  input  logic [MEM_DW-1:0] mem_rdata
);

  localparam int RW = $clog2(MAX_DATA_RUN + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_DATA_RUN);
  localparam logic [TW-1:0] T_LIM   = TW'(TIMEOUT - 1);

  arb_state_t r_state;
  arb_state_t w_next;

  logic [RW-1:0] r_run;
  logic [TW-1:0] r_tcnt;

  logic w_busy;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_ok;
  logic w_tout;
  logic w_fin;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [MEM_AW-1:0] r_mem_addr;
  logic [MEM_DW-1:0] r_mem_wdata;
  logic [MEM_BW-1:0] r_mem_be;

  logic              r_i_ack;
  logic              r_i_err;
  logic [MEM_DW-1:0] r_i_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [MEM_DW-1:0] r_d_rdata;

  // next state, grant decision and completion detection
  always_comb begin
    w_next  = r_state;
    w_gnt_i = 1'b0;
    w_gnt_d = 1'b0;
    w_ok    = 1'b0;
    w_tout  = 1'b0;
    w_busy  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_req && d_req) begin
          if (r_run < RUN_MAX) begin
            w_gnt_d = 1'b1;
          end else begin
            w_gnt_i = 1'b1;
          end
        end else if (i_req) begin
          w_gnt_i = 1'b1;
        end else if (d_req) begin
          w_gnt_d = 1'b1;
        end
        if (w_gnt_i) begin
          w_next = ST_BUSY_I;
        end else if (w_gnt_d) begin
          w_next = ST_BUSY_D;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        w_busy = 1'b1;
        if (mem_ack) begin
          w_ok = 1'b1;
        end else if (r_tcnt == T_LIM) begin
          w_tout = 1'b1;
        end
        if (w_ok || w_tout) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_fin = w_ok | w_tout;

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // data-run and busy-timeout counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run  <= '0;
      r_tcnt <= '0;
    end else begin
      if (w_gnt_i) begin
        r_run <= '0;
      end else if (w_gnt_d && (r_run != RUN_MAX)) begin
        r_run <= r_run + RW'(1);
      end
      if (w_gnt_i || w_gnt_d) begin
        r_tcnt <= '0;
      end else if (w_busy && !mem_ack) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  // latch the winner onto the memory bus
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else if (w_gnt_i) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= i_addr;
      r_mem_wdata <= '0;
      r_mem_be    <= {MEM_BW{1'b1}};
    end else if (w_gnt_d) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= d_we;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_wdata;
      r_mem_be    <= d_be;
    end else if (w_fin) begin
      r_mem_req   <= 1'b0;
    end
  end

  // response pulses; rdata holds until next response on that port
  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack <= 1'b0;
      r_i_err <= 1'b0;
      r_d_ack <= 1'b0;
      r_d_err <= 1'b0;
      if (w_fin && (r_state == ST_BUSY_I)) begin
        r_i_ack   <= 1'b1;
        r_i_err   <= w_tout;
        r_i_rdata <= w_ok ? mem_rdata : '0;
      end
      if (w_fin && (r_state == ST_BUSY_D)) begin
        r_d_ack   <= 1'b1;
        r_d_err   <= w_tout;
        r_d_rdata <= w_ok ? mem_rdata : '0;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;
  assign i_ack     = r_i_ack;
  assign i_err     = r_i_err;
  assign i_rdata   = r_i_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter
// memory responder, two requesters, transaction-level model
module tb_mem_arbiter;
  import akarin_pkg::*;

  localparam int MDR   = 4;
  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_arbiter #(
    .MAX_DATA_RUN(MDR),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .i_ack(i_ack), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gap;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          dur;
  } rsp_t;

  txn_t plan_i[$];
  txn_t plan_d[$];
  txn_t cur_i;
  txn_t cur_d;
  rsp_t rsp_q[$];
  bit   port_q[$];
  bit   gnt_log[$];

  int checks = 0;
  int errors = 0;

  bit          gr_i = 0;
  bit          gr_d = 0;
  bit          mon_en = 0;
  bit          spur_en = 1;
  int          force_lat = -1;
  logic [31:0] force_data = '0;

  int          m_run = 0;
  bit          prev_req = 0;
  bit          pi = 0;
  bit          pd = 0;
  logic [31:0] last_ir = '0;
  logic [31:0] last_dr = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    checks++;
    errors++;
    $display("FAIL %s: event seen, none expected", nm);
  endtask

  function automatic txn_t mk(logic we, logic [31:0] a,
                              logic [31:0] w, logic [3:0] be,
                              int gap);
    txn_t t;
    t.we = we;
    t.addr = a;
    t.wdata = w;
    t.be = be;
    t.gap = gap;
    return t;
  endfunction

  // memory responder: picks a latency per transaction, records outcome
  initial begin : mem_model
    int k;
    int lat;
    int r;
    k = 0;
    lat = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_req !== 1'b1) begin
        k = 0;
        mem_ack = spur_en && ($urandom_range(3, 0) == 0);
        mem_rdata = $urandom;
      end else begin
        if (k == 0) begin
          if (force_lat >= 0) begin
            lat = force_lat;
          end else begin
            r = $urandom_range(9, 0);
            if (r < 6) lat = $urandom_range(3, 0);
            else if (r < 8) lat = TO - 1;
            else lat = NEVER;
          end
        end
        mem_ack = (k == lat);
        if (k == lat && force_lat >= 0) mem_rdata = force_data;
        else mem_rdata = $urandom;
        if (k == lat) begin
          rsp_q.push_back('{data: mem_rdata, err: 1'b0, dur: k + 1});
        end else if (k == TO - 1) begin
          rsp_q.push_back('{data: 32'h0, err: 1'b1, dur: TO});
        end
        k++;
      end
    end
  end

  // instruction requester
  initial begin : drv_i
    int gc;
    int wc;
    gc = 0;
    wc = 0;
    i_req = 1'b0;
    i_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        i_req = 1'b0;
        gr_i = 0;
        wc = 0;
      end else if (i_req) begin
        if (i_ack) begin
          i_req = 1'b0;
          gr_i = 0;
          if (plan_i.size() > 0 && plan_i[0].gap == 0) begin
            cur_i = plan_i.pop_front();
            i_addr = cur_i.addr;
            i_req = 1'b1;
            wc = 0;
          end
        end else begin
          wc++;
          if (wc > 80) begin
            bad("i_wait_bound");
            i_req = 1'b0;
            gr_i = 0;
          end else if (gr_i && $urandom_range(1, 0) == 1) begin
            i_addr = $urandom;
          end
        end
      end else if (plan_i.size() > 0) begin
        if (gc < plan_i[0].gap) begin
          gc++;
        end else begin
          gc = 0;
          cur_i = plan_i.pop_front();
          i_addr = cur_i.addr;
          i_req = 1'b1;
          wc = 0;
        end
      end
    end
  end

  // data requester
  initial begin : drv_d
    int gc;
    int wc;
    gc = 0;
    wc = 0;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = '0;
    d_wdata = '0;
    d_be = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        d_req = 1'b0;
        gr_d = 0;
        wc = 0;
      end else if (d_req) begin
        if (d_ack) begin
          d_req = 1'b0;
          gr_d = 0;
          if (plan_d.size() > 0 && plan_d[0].gap == 0) begin
            cur_d = plan_d.pop_front();
            {d_we, d_addr} = {cur_d.we, cur_d.addr};
            {d_wdata, d_be} = {cur_d.wdata, cur_d.be};
            d_req = 1'b1;
            wc = 0;
          end
        end else begin
          wc++;
          if (wc > 80) begin
            bad("d_wait_bound");
            d_req = 1'b0;
            gr_d = 0;
          end else if (gr_d && $urandom_range(1, 0) == 1) begin
            d_we = ~d_we;
            d_addr = $urandom;
            d_wdata = $urandom;
            d_be = 4'($urandom);
          end
        end
      end else if (plan_d.size() > 0) begin
        if (gc < plan_d[0].gap) begin
          gc++;
        end else begin
          gc = 0;
          cur_d = plan_d.pop_front();
          {d_we, d_addr} = {cur_d.we, cur_d.addr};
          {d_wdata, d_be} = {cur_d.wdata, cur_d.be};
          d_req = 1'b1;
          wc = 0;
        end
      end
    end
  end

  // monitor: predicts each grant, checks bus hold and responses
  initial begin : monitor
    txn_t ex;
    bit   win;
    int   dur;
    rsp_t r;
    bit   p;
    dur = 0;
    win = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (i_ack && d_ack) bad("dual_ack");
        if (prev_req && !mem_req) begin
          chk("ack_in_resp", 32'(i_ack | d_ack), 32'd1);
          if (rsp_q.size() == 0 || port_q.size() == 0) begin
            bad("sb_empty");
          end else begin
            r = rsp_q.pop_front();
            p = port_q.pop_front();
            chk("busy_len", 32'(dur), 32'(r.dur));
            chk("ack_port", 32'(d_ack), 32'(p));
            if (p) begin
              chk("d_rdata", d_rdata, r.data);
              chk("d_err", 32'(d_err), 32'(r.err));
              chk("i_rdata_hold", i_rdata, last_ir);
              last_dr = r.data;
            end else begin
              chk("i_rdata", i_rdata, r.data);
              chk("i_err", 32'(i_err), 32'(r.err));
              chk("d_rdata_hold", d_rdata, last_dr);
              last_ir = r.data;
            end
          end
        end else if (i_ack || d_ack) begin
          bad("stray_ack");
        end
        if (mem_req && !prev_req) begin
          if (!pi && !pd) bad("grant_no_req");
          win = (pi && pd) ? (m_run < MDR) : pd;
          ex = win ? cur_d : cur_i;
          port_q.push_back(win);
          gnt_log.push_back(win);
          if (win) begin
            if (m_run < MDR) m_run++;
            gr_d = 1;
          end else begin
            m_run = 0;
            gr_i = 1;
          end
          dur = 0;
        end
        if (mem_req) begin
          dur++;
          chk("mem_addr", mem_addr, ex.addr);
          chk("mem_we", 32'(mem_we), 32'(ex.we));
          chk("mem_be", 32'(mem_be), 32'(ex.be));
          if (win) chk("mem_wdata", mem_wdata, ex.wdata);
        end
        prev_req = mem_req;
        pi = i_req;
        pd = d_req;
      end
    end
  end

  task automatic drain(int n);
    int c;
    c = 0;
    while (c < n && (plan_i.size() > 0 || plan_d.size() > 0 ||
                     i_req || d_req || mem_req)) begin
      @(negedge clk);
      c++;
    end
    if (c >= n) bad("drain_bound");
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_grants(int base, bit exp, string nm);
    if (gnt_log.size() <= base) bad(nm);
    else chk(nm, 32'(gnt_log[base]), 32'(exp));
  endtask

  // directed scenarios, random traffic, mid-transaction resets
  initial begin : main
    bit pat[10];
    int base;
    int c;
    bit acked;
    pat = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_be", 32'(mem_be), 0);
    chk("rst_i_ack", 32'(i_ack), 0);
    chk("rst_i_err", 32'(i_err), 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_ack", 32'(d_ack), 0);
    chk("rst_d_err", 32'(d_err), 0);
    chk("rst_d_rdata", d_rdata, 0);
    @(posedge clk);
    #2 rst = 1'b0;
    mon_en = 1;

    force_lat = 2;
    force_data = 32'hDEADBEEF;
    plan_i.push_back(mk(0, 32'h100, 0, 4'hF, 0));
    drain(200);
    chk("iread_rdata", i_rdata, 32'hDEADBEEF);
    chk("iread_err", 32'(i_err), 0);

    force_lat = 1;
    force_data = 32'hCAFEF00D;
    plan_d.push_back(mk(1, 32'h2000, 32'h12345678, 4'b0011, 0));
    drain(200);

    force_lat = NEVER;
    plan_d.push_back(mk(0, 32'h3000, 0, 4'hF, 0));
    drain(200);
    chk("tout_rdata", d_rdata, 0);

    force_lat = TO - 1;
    force_data = 32'h5A5A0001;
    plan_i.push_back(mk(0, 32'h440, 0, 4'hF, 0));
    drain(200);
    chk("edge_rdata", i_rdata, 32'h5A5A0001);

    force_lat = 0;
    base = gnt_log.size();
    for (int j = 0; j < 10; j++) begin
      plan_d.push_back(mk(j[0], 32'h8000 + 32'(j * 4),
                          32'(j), 4'hF, 0));
    end
    for (int j = 0; j < 3; j++) begin
      plan_i.push_back(mk(0, 32'h40 + 32'(j * 4), 0, 4'hF, 0));
    end
    drain(400);
    for (int j = 0; j < 10; j++) begin
      chk_grants(base + j, pat[j], "run_pattern");
    end

    force_lat = -1;
    for (int j = 0; j < 40; j++) begin
      plan_i.push_back(mk(0, $urandom, 0, 4'hF,
                          $urandom_range(4, 0)));
      plan_d.push_back(mk(1'($urandom), $urandom, $urandom,
                          4'($urandom), $urandom_range(4, 0)));
    end
    drain(6000);

    for (int t = 0; t < 2; t++) begin
      spur_en = 0;
      force_lat = 0;
      if (t == 1) begin
        for (int j = 0; j < 4; j++) begin
          plan_d.push_back(mk(0, 32'h600 + 32'(j), 0, 4'hF, 0));
        end
        drain(200);
      end
      force_lat = NEVER;
      if (t == 0) plan_i.push_back(mk(0, 32'h700, 0, 4'hF, 0));
      else plan_d.push_back(mk(0, 32'h704, 0, 4'hF, 0));
      c = 0;
      while (c < 20 && mem_req !== 1'b1) begin
        @(negedge clk);
        c++;
      end
      if (c >= 20) bad("rst_grant_bound");
      mon_en = 0;
      @(posedge clk);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_mem_req", 32'(mem_req), 0);
      chk("rst_mid_ack", 32'(i_ack | d_ack), 0);
      @(posedge clk);
      #2 rst = 1'b0;
      acked = 0;
      repeat (3) begin
        @(negedge clk);
        if (i_ack || d_ack) acked = 1;
      end
      chk("rst_no_ack", 32'(acked), 0);
      rsp_q.delete();
      port_q.delete();
      m_run = 0;
      prev_req = 0;
      pi = 0;
      pd = 0;
      last_ir = '0;
      last_dr = '0;
      force_lat = 0;
      mon_en = 1;
      base = gnt_log.size();
      plan_i.push_back(mk(0, 32'h900, 0, 4'hF, 0));
      plan_d.push_back(mk(1, 32'h904, 32'hA5, 4'h1, 0));
      plan_d.push_back(mk(0, 32'h908, 0, 4'hF, 0));
      drain(200);
      chk_grants(base, 1, "post_rst_first");
    end
    spur_en = 1;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
